multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control unit for the multicycle ARM-subset core. It sequences the shared datapath (one memory port, one ALU, instruction register) through fetch, decode, execute, memory and writeback states. It also owns the NZCV flag register and the condition-code check that gates every architectural write. It sits between the instruction register/ALU and the datapath mux and enable inputs, and replaces the single-cycle controller when the multicycle datapath is built.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; Funct[5]=I, Funct[0]=S (data-proc) or L (memory)
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write enable
- AdrSrc  out  1  0=PC, 1=ALU result register as memory address
- ALUSrcA  out  1  0=RD1 register, 1=PC
- ALUSrcB  out  2  00=WD register, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut register, 01=Data register, 10=ALU result
- ImmSrc  out  2  equals Op
- RegSrc  out  2  {Op==01, Op==10}
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- States and Moore decode. Unlisted outputs are 0; AdrSrc/ALUSrc*/ResultSrc default to 0.
  - FETCH (0): AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE (1): ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Latches CondExL.
  - MEMADR (2): ALUSrcB=01.
  - MEMRD (3): AdrSrc=1.
  - MEMWB (4): ResultSrc=01, RegW=1.
  - MEMWR (5): AdrSrc=1, MemW=1.
  - EXECR (6): ALUSrcB=00, ALUOp=1.
  - EXECI (7): ALUSrcB=01, ALUOp=1.
  - ALUWB (8): ResultSrc=00, RegW=1.
  - BRANCH (9): ALUSrcB=01, ResultSrc=10, Branch=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECR; Op=00 with Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH (undefined opcode, no side effects).
  - MEMADR→MEMRD if Funct[0], else MEMWR.
  - MEMRD→MEMWB→FETCH; MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH; BRANCH→FETCH.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, by Funct[4:1]: 0100→00, 0010→01, 0000→10, 1100→11. Any other value→00 with FlagW=00.
  - FlagW[1] (N,Z) = Funct[0].
  - FlagW[0] (C,V) = Funct[0] & (ALUControl is 00 or 01).
- Condition check uses registered Flags {N,Z,C,V}; GE = (N==V).
  - Cond 0000–0111: EQ, NE, CS, CC, MI, PL, VS, VC.
  - Cond 1000 HI = C&~Z; 1001 LS = ~(C&~Z).
  - Cond 1010 GE; 1011 LT; 1100 GT = ~Z&GE; 1101 LE = Z|~GE.
  - Cond 1110 AL = 1; 1111 → 0 (never execute).
- CondExL is captured at the end of DECODE and held until the next DECODE. Flag updates during EXEC do not affect the current instruction's writeback.
- PCS = Branch | (RegW & Rd==15).
- Write gating:
  - PCWrite = NextPC | (PCS & CondExL).
  - RegWrite = RegW & CondExL & ~NoWrite.
  - MemWrite = MemW & CondExL.
- Flags[3:2] load ALUFlags[3:2] on a clock edge in EXECR/EXECI when FlagW[1] & CondExL. Flags[1:0] load likewise under FlagW[0].

## Timing
- Reset (reset=0 at a clock edge): state=FETCH, Flags=0000, CondExL=0, NoWrite latch=0.
- While reset=0, PCWrite, IRWrite, RegWrite and MemWrite are forced 0. Other outputs follow FETCH decode.
- First FETCH executes in the first cycle with reset=1.
- Reset asserted mid-instruction aborts it. No write enable fires in the reset cycle.
- Latency in cycles, FETCH to the next FETCH: LDR 5, STR 4, data-processing 4, B 3, undefined 2.
- All outputs are combinational from state, the latched registers and the instruction fields. The instruction register is stable from DECODE onward.
- A failed condition still walks the full state sequence, with all gated writes suppressed.

## Configuration
- CTRL_CMP_EN defined:
  - Funct[4:1]=1010 (CMP) decodes to ALUControl=01 with FlagW as for SUB.
  - Sets NoWrite, latched in DECODE, which suppresses RegWrite in ALUWB. PC-write via PCS is still suppressed because RegW&Rd==15 is masked by NoWrite.
- CTRL_CMP_EN undefined: 1010 decodes as undefined (ALUControl=00, FlagW=00); NoWrite is tied 0.

## Test plan
- Reset held 3 cycles, then released with ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000) → state sequence 0,1,6,8,0; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- LDR (Op=01, Funct=011001) → states 0,1,2,3,4,0; AdrSrc=1 in MEMRD; RegWrite in MEMWB. STR (Funct=011000) → states 0,1,2,5,0; MemWrite=1 in MEMWR only.
- SUBS setting Z=1 (ALUFlags=0100 in EXECR), then ADDEQ R4 → ADDEQ's RegWrite=1. A following ADDNE → RegWrite=0, and its states still go 0,1,6,8,0.
- BEQ with Z=0 → states 0,1,9,0 with PCWrite=0 in BRANCH. BAL → PCWrite=1 in BRANCH.
- ADDS with Cond=1110 writing Rd=15 → PCWrite=1 and RegWrite=1 in ALUWB. Flags updated at the end of EXECR, not ALUWB.
- With CTRL_CMP_EN: CMP R1,R2 (Funct=010101) → ALUControl=01 in EXECR, flags load, RegWrite=0 in ALUWB. Without the macro → ALUControl=00, no flag change.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset controller: FSM sequencing, ALU decode, NZCV flags and condition gating.
// Optional CMP support (ALUControl=SUB, flags only, no register write) is enabled by defining CTRL_CMP_EN.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d, st;
    logic [3:0] flags_q, flags_d;
    logic       condexl_q, condexl_d;
    logic       nowrite_q, nowrite_d;

    logic       nextpc, irw, regw, memw, branch, aluop;
    logic [1:0] flagw;
    logic       dec_ok, is_cmp, condex, pcs;

    // While in reset the decode behaves as FETCH regardless of the stale state register
    assign st = reset ? state_q : FETCH;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH;
            flags_q   <= 4'b0000;
            condexl_q <= 1'b0;
            nowrite_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            condexl_q <= condexl_d;
            nowrite_q <= nowrite_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        nextpc    = 1'b0;
        irw       = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        aluop     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (st)
            FETCH:  begin irw = 1'b1; nextpc = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            DECODE: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB:  begin ResultSrc = 2'b01; regw = 1'b1; end
            MEMWR:  begin AdrSrc = 1'b1; memw = 1'b1; end
            EXECR:  begin ALUSrcB = 2'b00; aluop = 1'b1; end
            EXECI:  begin ALUSrcB = 2'b01; aluop = 1'b1; end
            ALUWB:  begin ResultSrc = 2'b00; regw = 1'b1; end
            BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
            default: ;
        endcase
    end

    // ALU decode; unrecognised function codes fall back to ADD without touching flags
    always_comb begin
        ALUControl = 2'b00;
        dec_ok     = 1'b0;
        is_cmp     = 1'b0;
        case (Funct[4:1])
            4'b0100: begin ALUControl = 2'b00; dec_ok = 1'b1; end
            4'b0010: begin ALUControl = 2'b01; dec_ok = 1'b1; end
            4'b0000: begin ALUControl = 2'b10; dec_ok = 1'b1; end
            4'b1100: begin ALUControl = 2'b11; dec_ok = 1'b1; end
`ifdef CTRL_CMP_EN
            4'b1010: begin ALUControl = 2'b01; dec_ok = 1'b1; is_cmp = 1'b1; end
`endif
            default: ;
        endcase
        if (!aluop) begin
            ALUControl = 2'b00;
            dec_ok     = 1'b0;
        end
        flagw[1] = dec_ok & Funct[0];
        flagw[0] = dec_ok & Funct[0] & ~ALUControl[1];
    end

    always_comb begin
        case (Cond)
            4'b0000: condex = flags_q[2];
            4'b0001: condex = ~flags_q[2];
            4'b0010: condex = flags_q[1];
            4'b0011: condex = ~flags_q[1];
            4'b0100: condex = flags_q[3];
            4'b0101: condex = ~flags_q[3];
            4'b0110: condex = flags_q[0];
            4'b0111: condex = ~flags_q[0];
            4'b1000: condex = flags_q[1] & ~flags_q[2];
            4'b1001: condex = ~(flags_q[1] & ~flags_q[2]);
            4'b1010: condex = (flags_q[3] == flags_q[0]);
            4'b1011: condex = (flags_q[3] != flags_q[0]);
            4'b1100: condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: condex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // Condition and CMP status are frozen in DECODE so EXEC flag updates cannot affect writeback
    always_comb begin
        condexl_d = condexl_q;
        nowrite_d = nowrite_q;
        flags_d   = flags_q;
        if (state_q == DECODE) begin
            condexl_d = condex;
            nowrite_d = is_cmp & (Op == 2'b00);
        end
        if (((state_q == EXECR) || (state_q == EXECI)) && condexl_q) begin
            if (flagw[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flagw[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    assign pcs      = branch | (regw & ~nowrite_q & (Rd == 4'd15));
    assign PCWrite  = reset & (nextpc | (pcs & condexl_q));
    assign IRWrite  = reset & irw;
    assign RegWrite = reset & regw & condexl_q & ~nowrite_q;
    assign MemWrite = reset & memw & condexl_q;
    assign ImmSrc   = Op;
    assign RegSrc   = {Op == 2'b01, Op == 2'b10};
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction cycle traces from an ISA-level model, checked by a monitor.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        string       tag;
    } exp_t;

    exp_t       expq[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [3:0] mflags = 4'b0000;

    wire [15:0] act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                       ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

    // Monitor: one expected output vector per clock cycle while enabled
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL underflow: got %h with no expected vector queued", act);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", e.tag, act, e.v, $time);
                end
            end
        end
    end

    function automatic logic [15:0] rec(input logic [1:0] op, input logic pcw, irw, rw, mw, adr, sa,
                                        input logic [1:0] sb, rs, ctl);
        return {pcw, irw, rw, mw, adr, sa, sb, rs, op, op == 2'b01, op == 2'b10, ctl};
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !(cy && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Issue one instruction; abort_at>0 asserts reset after that many cycles
    task automatic issue(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                         input logic [3:0] rd, input logic [3:0] af, input int abort_at);
        exp_t tr[$];
        bit ok, valid, nw, wr15;
        logic [1:0] ctl;
        int n;
        ok = cond_ok(c, mflags);
        wr15 = (rd == 4'd15);
        tr.push_back('{rec(op, 1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0), "fetch"});
        tr.push_back('{rec(op, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0), "decode"});
        case (op)
            2'b01: begin
                tr.push_back('{rec(op, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0), "memadr"});
                if (fn[0]) begin
                    tr.push_back('{rec(op, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0), "memrd"});
                    tr.push_back('{rec(op, ok && wr15, 0, ok, 0, 0, 0, 2'd0, 2'd1, 2'd0), "memwb"});
                end else begin
                    tr.push_back('{rec(op, 0, 0, 0, ok, 1, 0, 2'd0, 2'd0, 2'd0), "memwr"});
                end
            end
            2'b00: begin
                valid = 1'b1;
                nw = 1'b0;
                case (fn[4:1])
                    4'b0100: ctl = 2'd0;
                    4'b0010: ctl = 2'd1;
                    4'b0000: ctl = 2'd2;
                    4'b1100: ctl = 2'd3;
`ifdef CTRL_CMP_EN
                    4'b1010: begin ctl = 2'd1; nw = 1'b1; end
`endif
                    default: begin ctl = 2'd0; valid = 1'b0; end
                endcase
                tr.push_back('{rec(op, 0, 0, 0, 0, 0, 0, fn[5] ? 2'd1 : 2'd0, 2'd0, ctl), "exec"});
                tr.push_back('{rec(op, ok && !nw && wr15, 0, ok && !nw, 0, 0, 0, 2'd0, 2'd0, 2'd0), "aluwb"});
                if (ok && valid && fn[0] && abort_at == 0) begin
                    mflags[3:2] = af[3:2];
                    if (ctl < 2'd2) mflags[1:0] = af[1:0];
                end
            end
            2'b10: tr.push_back('{rec(op, ok, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0), "branch"});
            default: ;
        endcase
        Cond = c; Op = op; Funct = fn; Rd = rd;
        n = (abort_at > 0) ? abort_at : tr.size();
        for (int i = 0; i < n; i++) expq.push_back(tr[i]);
        for (int i = 0; i < n; i++) begin
            // Real flags only in the execute cycle; noise elsewhere must never be loaded
            ALUFlags = (i == 2) ? af : 4'($urandom);
            @(posedge clk); #1;
        end
        if (abort_at > 0) begin
            reset = 1'b0;
            expq.push_back('{rec(op, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0), "abort_reset"});
            @(posedge clk); #1;
            reset = 1'b1;
            mflags = 4'b0000;
        end
    endtask

    initial begin
        reset = 1'b0; Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (3) begin
            expq.push_back('{rec(Op, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0), "reset"});
            @(posedge clk); #1;
        end
        reset = 1'b1;
        issue(4'hE, 2'b00, 6'b001000, 4'd1,  4'b0000, 0);  // ADD R1
        issue(4'hE, 2'b01, 6'b011001, 4'd2,  4'b0000, 0);  // LDR
        issue(4'hE, 2'b01, 6'b011000, 4'd2,  4'b0000, 0);  // STR
        issue(4'hE, 2'b00, 6'b000101, 4'd3,  4'b0100, 0);  // SUBS -> Z=1
        issue(4'h0, 2'b00, 6'b001000, 4'd4,  4'b0000, 0);  // ADDEQ executes
        issue(4'h1, 2'b00, 6'b001000, 4'd4,  4'b0000, 0);  // ADDNE suppressed
        issue(4'hE, 2'b00, 6'b001001, 4'd5,  4'b0000, 0);  // ADDS clears flags
        issue(4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, 0);  // BEQ not taken
        issue(4'hE, 2'b10, 6'b100000, 4'd0,  4'b0000, 0);  // BAL
        issue(4'hE, 2'b00, 6'b001001, 4'd15, 4'b1010, 0);  // ADDS PC
        issue(4'hA, 2'b00, 6'b001000, 4'd6,  4'b0000, 0);  // ADDGE (N=1,V=0 -> fails)
        issue(4'hE, 2'b00, 6'b010101, 4'd1,  4'b0110, 0);  // CMP
        issue(4'h0, 2'b00, 6'b001000, 4'd7,  4'b0000, 0);  // ADDEQ, depends on CMP flag load
        issue(4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 0);  // undefined opcode
        issue(4'hF, 2'b00, 6'b001000, 4'd1,  4'b0000, 0);  // never
        issue(4'hE, 2'b01, 6'b011001, 4'd3,  4'b0000, 2);  // LDR aborted by reset
        issue(4'hD, 2'b00, 6'b001000, 4'd2,  4'b0000, 0);  // ADDLE after reset (flags 0 -> fails)
        for (int k = 0; k < 300; k++)
            issue(4'($urandom), 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 2)) : 0);
        mon_en = 1'b0;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected vectors never checked, required 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
